async_fifo_wr_arbiter: RTL and testbench

//   Shares the single write port of an async FIFO (write-pointer/full control side)

---
 rtl/async_fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------------------------
// async_fifo_wr_arbiter
//   Shares the single write port of an async FIFO between NUM_REQ requesters in the write
//   clock domain. Arbitration is round-robin and packet-aware: a grant is held until the
//   granted requester writes its last beat or MAX_BURST beats, whichever comes first.
//   Writes are throttled by the FIFO full flag.
//
// Ports
//   clk_i        write-domain clock
//   reset_i      synchronous reset, active-high
//   req_valid_i  per-requester beat valid
//   req_last_i   per-requester last beat of packet
//   req_data_i   requester r data at [r*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o  per-requester ready; beat accepted when valid & ready
//   wfull_i      FIFO full flag
//   wr_en_o      FIFO write enable
//   wdata_o      FIFO write data
//   grant_o      one-hot current grant, 0 when idle
//   busy_o       high while a burst is in progress
// ---------------------------------------------------------------------------------------------
module async_fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          wfull_i,
   output logic                          wr_en_o,
   output logic [DATA_WIDTH-1:0]         wdata_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e             r_state,    w_state_nxt;
   logic [NUM_REQ-1:0] r_grant,    w_grant_nxt;
   logic [PTR_W-1:0]   r_gidx,     w_gidx_nxt;
   logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
   logic [PTR_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;

   logic               w_pick_found;
   logic [PTR_W-1:0]   w_pick_idx;
   logic [31:0]        w_cand;
   logic               w_busy;
   logic               w_xfer;
   logic               w_last;
   logic               w_cap;

   // Round-robin search: first valid requester after the last one served, wrapping modulo
   // NUM_REQ so non-power-of-two requester counts work.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_cand = (32'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_pick_found && req_valid_i[w_cand[PTR_W-1:0]]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand[PTR_W-1:0];
         end
      end
   end

   assign w_busy = (r_state == StBurst);
   assign w_xfer = w_busy & req_valid_i[r_gidx] & ~wfull_i;
   assign w_last = req_last_i[r_gidx];
   assign w_cap  = (r_beat_cnt == CNT_W'(MAX_BURST - 1));

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_gidx_nxt     = r_gidx;
      w_beat_cnt_nxt = r_beat_cnt;
      w_rr_ptr_nxt   = r_rr_ptr;
      case (r_state)
         StIdle: begin
            if (w_pick_found) begin
               w_state_nxt    = StBurst;
               w_grant_nxt    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
               w_gidx_nxt     = w_pick_idx;
               w_beat_cnt_nxt = '0;
            end
         end
         StBurst: begin
            if (w_xfer) begin
               w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
               // Packet end or burst cap: release and let the others compete.
               if (w_last || w_cap) begin
                  w_state_nxt    = StIdle;
                  w_grant_nxt    = '0;
                  w_rr_ptr_nxt   = r_gidx;
                  w_beat_cnt_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= StIdle;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_beat_cnt <= '0;
         // Pointer at the last requester so requester 0 has first priority.
         r_rr_ptr   <= PTR_W'(NUM_REQ - 1);
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_gidx     <= w_gidx_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
      end
   end

   assign busy_o      = w_busy;
   assign grant_o     = r_grant;
   assign req_ready_o = (w_busy && !wfull_i) ? r_grant : '0;
   assign wr_en_o     = w_xfer;
   assign wdata_o     = w_busy ? req_data_i[r_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_async_fifo_wr_arbiter
//   Cycle-by-cycle vectors for the arbiter: a table covers reset, round-robin order, a single
//   packet and backpressure; hand-written sequences cover the burst cap and reset mid-burst.
//   Expected write data is queued when a write is expected and compared when wr_en_o fires.
// ---------------------------------------------------------------------------------------------
module tb_async_fifo_wr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 32;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [NR-1:0]    req_valid_i;
   logic [NR-1:0]    req_last_i;
   logic [NR*DW-1:0] req_data_i;
   logic [NR-1:0]    req_ready_o;
   logic             wfull_i;
   logic             wr_en_o;
   logic [DW-1:0]    wdata_o;
   logic [NR-1:0]    grant_o;
   logic             busy_o;

   async_fifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .MAX_BURST (8)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_valid_i(req_valid_i),
      .req_last_i (req_last_i),
      .req_data_i (req_data_i),
      .req_ready_o(req_ready_o),
      .wfull_i    (wfull_i),
      .wr_en_o    (wr_en_o),
      .wdata_o    (wdata_o),
      .grant_o    (grant_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          rst;
      logic [NR-1:0] vld;
      logic [NR-1:0] lst;
      logic          full;
      logic [NR-1:0] grant;
      logic [NR-1:0] rdy;
      logic          wen;
      logic          busy;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [DW-1:0] sb[$];
   int unsigned seq[NR];
   vec_t        vecs[$];

   function automatic vec_t mk(input logic rst, input logic [NR-1:0] vld,
                               input logic [NR-1:0] lst, input logic full,
                               input logic [NR-1:0] grant, input logic [NR-1:0] rdy,
                               input logic wen, input logic busy);
      vec_t v;
      v.rst = rst; v.vld = vld; v.lst = lst; v.full = full;
      v.grant = grant; v.rdy = rdy; v.wen = wen; v.busy = busy;
      return v;
   endfunction

   function automatic logic [DW-1:0] data_of(input int unsigned r, input int unsigned s);
      return {8'hA0, 8'h00, r[7:0], s[7:0]};
   endfunction

   function automatic int unsigned idx_of(input logic [NR-1:0] oh);
      int unsigned idx = 0;
      for (int unsigned i = 0; i < NR; i++) if (oh[i]) idx = i;
      return idx;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_data();
      for (int unsigned r = 0; r < NR; r++) req_data_i[r*DW +: DW] = data_of(r, seq[r]);
   endtask

   // One cycle: drive after the edge, check combinational outputs at the falling edge.
   task automatic apply(input vec_t v, input string tag);
      int unsigned gi;
      logic [DW-1:0] exp_wdata;
      gi          = idx_of(v.grant);
      reset_i     = v.rst;
      req_valid_i = v.vld;
      req_last_i  = v.lst;
      wfull_i     = v.full;
      drive_data();
      if (v.wen) sb.push_back(data_of(gi, seq[gi]));
      exp_wdata = v.busy ? data_of(gi, seq[gi]) : '0;
      @(negedge clk_i);
      chk({tag, "_grant"}, 64'(grant_o), 64'(v.grant));
      chk({tag, "_ready"}, 64'(req_ready_o), 64'(v.rdy));
      chk({tag, "_wr_en"}, 64'(wr_en_o), 64'(v.wen));
      chk({tag, "_busy"}, 64'(busy_o), 64'(v.busy));
      chk({tag, "_wdata"}, 64'(wdata_o), 64'(exp_wdata));
      @(posedge clk_i);
      #1;
      if (v.wen) seq[gi]++;
   endtask

   // Scoreboard: every FIFO write must match the oldest expected beat.
   always @(negedge clk_i) begin
      if (wr_en_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_write: got wdata %0h expected no write at %0t",
                     wdata_o, $time);
         end else begin
            chk("sb_wdata", 64'(wdata_o), 64'(sb.pop_front()));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int unsigned r = 0; r < NR; r++) seq[r] = 0;
      reset_i     = 1'b1;
      req_valid_i = '0;
      req_last_i  = '0;
      wfull_i     = 1'b0;
      drive_data();
      @(posedge clk_i);
      #1;

      // Reset with all requesters valid, then single-beat round robin 0,1,2,3,0.
      vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0001, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0010, 4'b0010, 1, 1));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0100, 4'b0100, 1, 1));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b1000, 4'b1000, 1, 1));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'b0001, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 4'b0000, 4'b0000, 0, 0));
      // Single 3-beat packet from requester 0.
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0));
      // 4-beat packet from requester 1, FIFO full for 5 cycles after beat 2.
      vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1));
      vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 0, 1));
      vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1));
      vecs.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0));

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Burst cap: requester 2 streams 12 beats with no last while requester 1 waits.
      apply(mk(0, 4'b0110, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0), "cap_idle0");
      for (int i = 0; i < 8; i++)
         apply(mk(0, 4'b0110, 4'b0010, 0, 4'b0100, 4'b0100, 1, 1), $sformatf("cap_b%0d", i));
      apply(mk(0, 4'b0110, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0), "cap_idle1");
      apply(mk(0, 4'b0110, 4'b0010, 0, 4'b0010, 4'b0010, 1, 1), "cap_req1");
      apply(mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0), "cap_idle2");
      for (int i = 0; i < 4; i++)
         apply(mk(0, 4'b0100, (i == 3) ? 4'b0100 : 4'b0000, 0, 4'b0100, 4'b0100, 1, 1),
               $sformatf("cap_r%0d", i + 8));
      apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0), "cap_done");

      // Reset mid-burst of requester 3; afterwards requester 0 wins over requester 3.
      apply(mk(0, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0), "rst_idle");
      apply(mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 4'b1000, 1, 1), "rst_b0");
      apply(mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 4'b1000, 1, 1), "rst_b1");
      apply(mk(1, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 0, 1), "rst_assert");
      apply(mk(0, 4'b1001, 4'b1001, 0, 4'b0000, 4'b0000, 0, 0), "rst_after");
      apply(mk(0, 4'b1001, 4'b1001, 0, 4'b0001, 4'b0001, 1, 1), "rst_req0");
      apply(mk(0, 4'b1000, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0), "rst_idle2");
      apply(mk(0, 4'b1000, 4'b1000, 0, 4'b1000, 4'b1000, 1, 1), "rst_req3");
      apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0), "rst_done");

      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
